crc_stream: RTL
===============

Name: crc_stream

Overview:
- Parametrised multi-byte CRC engine. Successor to the byte-serial CRC32 LUT block.
- Consumes framed data BYTES per cycle over a valid/ready stream and produces one CRC result per frame on a valid/ready output.
- Configurable polynomial, init, final XOR and bit order. A check mode flags whether a frame carrying its own appended CRC ends in the expected residue.
- Sits between a MAC/packet source and the frame checker/inserter.

Parameters:
BYTES, 4, data bytes per beat (1..8); in_data width is 8*BYTES
POLY, 32'h04C11DB7, generator polynomial in normal (MSB-first) form
INIT, 32'hFFFFFFFF, CRC register value at start of frame
XOROUT, 32'hFFFFFFFF, XOR applied to register to form out_crc
REFLECT, 1, 1 = LSB-first (reflected, right-shift); 0 = MSB-first (left-shift)
RESIDUE, 32'hDEBB20E3, raw register value (before XOROUT) indicating a good frame

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  engine can accept a beat
in_data  input  8*BYTES  beat data; byte 0 = in_data[7:0], processed first
in_keep  input  BYTES  per-byte enable; bytes with keep=0 are skipped
in_sof  input  1  beat is first of frame
in_eof  input  1  beat is last of frame
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_crc  output  32  register ^ XOROUT
out_match  output  1  register == RESIDUE
out_len  output  16  bytes processed in frame, saturating at 16'hFFFF
err_pulse  output  1  one-cycle protocol-error strobe

Behaviour:
- Reset (async, rst_n=0): state=IDLE, register=INIT, out_len=0, out_valid=0, err_pulse=0, in_ready=1 after reset release. out_crc and out_match reflect the reset register.
- Beat accepted when in_valid & in_ready.
- Per-beat update is fully combinational: the enabled bytes are processed in ascending index order within one cycle. Each byte is 8 bit-serial steps, LSB-first (REFLECT=1, reflected POLY) or MSB-first (REFLECT=0).
- State machine: IDLE, RUN, RESULT.
- IDLE: in_ready=1.
  - Accepted beat with sof: register = update(INIT, beat); out_len = popcount(keep).
  - If eof is also set on that beat: go to RESULT. Otherwise go to RUN.
  - Accepted beat without sof: dropped, err_pulse=1, stay IDLE.
- RUN: in_ready=1.
  - Accepted beat: register = update(register, beat); out_len += popcount(keep), saturating.
  - eof → RESULT.
  - Beat with sof: current frame aborted, no result emitted, err_pulse=1. Frame restarts from INIT with this beat, same rules as IDLE.
- RESULT: in_ready=0, out_valid=1. out_crc, out_match and out_len are stable until out_valid & out_ready. On handshake → IDLE, register=INIT.
- Latency: eof beat accepted at edge N → out_valid=1 in the cycle after edge N.
- Throughput: one beat/cycle inside a frame; one idle cycle per frame minimum (RESULT).
- keep=0 on any beat is legal. Zero bytes processed; eof still closes the frame.
- Simultaneous sof+eof in RUN: abort plus single-beat frame, err_pulse=1, → RESULT.
- Reset mid-frame or in RESULT: pending result lost, outputs return to reset values.
- err_pulse is registered, high exactly one cycle per offending beat.

Test Plan:
- BYTES=4, default params; beats "1234" (sof), "5678", "9" (eof, keep=4'b0001) → out_crc=32'hCBF43926, out_len=9, out_match=0, out_valid the cycle after the eof beat.
- Same frame followed by bytes 26 39 F4 CB (eof on the final beat, keep adjusted) → out_match=1, out_crc=32'h2144DF1C, out_len=13.
- REFLECT=0, other params default, "123456789" → out_crc=32'hFC891918.
- out_ready held low 5 cycles in RESULT → out_valid and out_crc stable, in_ready=0, next frame stalled. Release → IDLE, next frame result correct.
- Beat without sof in IDLE, then sof mid-frame → err_pulse one cycle each. Only the restarted frame yields a result, with CRC of the restarted data only.
- rst_n asserted mid-frame and then in RESULT → out_valid=0 immediately; next frame "123456789" → 32'hCBF43926.

Source files
------------

// File: rtl/crc_stream.sv
// Framed multi-byte CRC engine: up to BYTES bytes folded per beat, one result per frame
// handed off on a valid/ready output, with optional residue check for self-checked frames.

module crc_byte #(
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter bit          REFLECT = 1'b1
) (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    input  logic        en,
    output logic [31:0] crc_out
);
    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    localparam logic [31:0] POLY_R = rev32(POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        if (REFLECT) begin
            c = c ^ {24'd0, data};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
        end else begin
            c = c ^ {data, 24'd0};
            for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        crc_out = en ? c : crc_in;
    end
endmodule

module crc_stream #(
    parameter int          BYTES   = 4,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
    parameter bit          REFLECT = 1'b1,
    parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*BYTES-1:0] in_data,
    input  logic [BYTES-1:0]   in_keep,
    input  logic               in_sof,
    input  logic               in_eof,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_crc,
    output logic               out_match,
    output logic [15:0]        out_len,
    output logic               err_pulse
);
    typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;

    state_t             state, state_d;
    logic [31:0]        crc_q, crc_d;
    logic [15:0]        len_q, len_d;
    logic               err_q, err_d;
    logic               accept;
    logic [BYTES:0][31:0] chain;
    logic [3:0]         nbytes;
    logic [16:0]        len_sum;
    logic [15:0]        len_sat;

    assign accept = in_valid && in_ready;

    // A sof beat always restarts from INIT, which also covers the abort-and-restart case.
    assign chain[0] = in_sof ? INIT : crc_q;

    generate
        for (genvar i = 0; i < BYTES; i++) begin : g_lane
            crc_byte #(.POLY(POLY), .REFLECT(REFLECT)) u_byte (
                .crc_in (chain[i]),
                .data   (in_data[8*i +: 8]),
                .en     (in_keep[i]),
                .crc_out(chain[i+1])
            );
        end
    endgenerate

    always_comb begin
        nbytes = '0;
        for (int i = 0; i < BYTES; i++)
            if (in_keep[i]) nbytes = nbytes + 4'd1;
        len_sum = (in_sof ? 17'd0 : {1'b0, len_q}) + {13'd0, nbytes};
        len_sat = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    end

    always_comb begin
        state_d = state;
        crc_d   = crc_q;
        len_d   = len_q;
        err_d   = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (accept) begin
                    if (in_sof || state == RUN) begin
                        crc_d   = chain[BYTES];
                        len_d   = len_sat;
                        err_d   = in_sof && (state == RUN);
                        state_d = in_eof ? RESULT : RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_d = IDLE;
                    crc_d   = INIT;
                    len_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            crc_q <= INIT;
            len_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            crc_q <= crc_d;
            len_q <= len_d;
            err_q <= err_d;
        end
    end

    assign in_ready  = (state != RESULT);
    assign out_valid = (state == RESULT);
    assign out_crc   = crc_q ^ XOROUT;
    assign out_match = (crc_q == RESIDUE);
    assign out_len   = len_q;
    assign err_pulse = err_q;
endmodule
